// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, FSM encoding and flag bit positions for the
// ALU issue sequencer. ALU_SEQ_ADDC_EN makes ADDC (1100) a legal opcode.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XNOR = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_LSL  = 4'b0111;
  localparam logic [3:0] OP_LSR  = 4'b1000;
  localparam logic [3:0] OP_STC  = 4'b1001;
  localparam logic [3:0] OP_ADDC = 4'b1100;
  localparam logic [3:0] OP_IDLE = 4'b1111;

  localparam int FLAG_Z  = 3;
  localparam int FLAG_C  = 2;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 0;

`ifdef ALU_SEQ_ADDC_EN
  localparam logic ADDC_EN = 1'b1;
`else
  localparam logic ADDC_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_XNOR, OP_SUB,
      OP_LSL, OP_LSR, OP_STC: ok = 1'b1;
      OP_ADDC:                ok = ADDC_EN;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// alu_flag_reg: persistent {Z,C,GT,LT} register, per-op update enables,
// and the carry-chain feed of C into the next ADDC carry-in.
module alu_flag_reg
  import alu_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       upd,
  input  logic [3:0] cap_op,
  input  logic       res_zero,
  input  logic       alu_cout,
  input  logic       alu_gt,
  input  logic       alu_lt,
  input  logic       alu_zero,
  input  logic [3:0] issue_op,
  output logic [3:0] flags,
  output logic       cin_next
);

  logic c_en, cmp_en, z_val;

  // Which flags the captured op is allowed to touch
  always_comb begin
    c_en   = upd && (cap_op == OP_ADD || cap_op == OP_SUB || cap_op == OP_ADDC);
    cmp_en = upd && (cap_op == OP_SUB);
    z_val  = (cap_op == OP_SUB) ? alu_zero : res_zero;
  end

  // Flag register; Z follows every legal capture
  always_ff @(posedge clock) begin
    if (reset) begin
      flags <= 4'b0000;
    end else begin
      if (upd)    flags[FLAG_Z]  <= z_val;
      if (c_en)   flags[FLAG_C]  <= alu_cout;
      if (cmp_en) flags[FLAG_GT] <= alu_gt;
      if (cmp_en) flags[FLAG_LT] <= alu_lt;
    end
  end

  // ADDC chains the current carry; all other ops issue with carry-in 0
  always_comb begin
    cin_next = ADDC_EN && (issue_op == OP_ADDC) && flags[FLAG_C];
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU request at a time, holds operands for the
// op latency, captures result/flags and returns a tagged response.
// ALU_SEQ_ADDC_EN enables the ADDC opcode and the C -> cin_o chain.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4,
  parameter int MATCH_LAT  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic [DATA_WIDTH-1:0] alu_in1_o,
  output logic [DATA_WIDTH-1:0] alu_in2_o,
  output logic [3:0]            aluctrl_o,
  output logic                  cin_o,
  input  logic [DATA_WIDTH-1:0] alu_res_i,
  input  logic                  alu_cout_i,
  input  logic                  alu_gt_i,
  input  logic                  alu_lt_i,
  input  logic                  alu_zero_i,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_err,
  output logic [3:0]            flags_o
);

  localparam logic [3:0] STC_LAT = 4'(MATCH_LAT);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] op_q;
  logic       capture;
  logic       cin_next;

  // Capture edge: counter has run down while operands are being driven
  always_comb begin
    capture = (state == S_ISSUE || state == S_WAIT) && (cnt == 4'd0);
  end

  alu_flag_reg u_flags (
    .clock    (clock),
    .reset    (reset),
    .upd      (capture),
    .cap_op   (op_q),
    .res_zero (alu_res_i == '0),
    .alu_cout (alu_cout_i),
    .alu_gt   (alu_gt_i),
    .alu_lt   (alu_lt_i),
    .alu_zero (alu_zero_i),
    .issue_op (req_op),
    .flags    (flags_o),
    .cin_next (cin_next)
  );

  // Issue FSM with registered drive and response outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      op_q      <= OP_IDLE;
      req_ready <= 1'b1;
      alu_in1_o <= '0;
      alu_in2_o <= '0;
      aluctrl_o <= OP_IDLE;
      cin_o     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_tag   <= req_tag;
            op_q      <= req_op;
            if (op_legal(req_op)) begin
              alu_in1_o <= req_a;
              alu_in2_o <= req_b;
              aluctrl_o <= (req_op == OP_ADDC) ? OP_ADD : req_op;
              cin_o     <= cin_next;
              cnt       <= (req_op == OP_STC) ? STC_LAT : 4'd0;
              rsp_err   <= 1'b0;
              state     <= S_ISSUE;
            end else begin
              // Illegal op never reaches the ALU
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_data  <= alu_res_i;
            rsp_valid <= 1'b1;
            alu_in1_o <= '0;
            alu_in2_o <= '0;
            aluctrl_o <= OP_IDLE;
            cin_o     <= 1'b0;
            state     <= S_RESP;
          end else begin
            cnt   <= cnt - 4'd1;
            state <= S_WAIT;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
